// File: rtl/alu_result_serializer_if.sv
// Bundles the four ALU unit results/valid levels and the byte-stream handshake with status.
// master drives unit results and TX_READY; slave is the serializer.
interface alu_result_serializer_if #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 16
);
  logic [RESULT_WIDTH-1:0]  ARITH_OUT;
  logic                     ARITH_Flag;
  logic [OPERAND_WIDTH-1:0] LOGIC_OUT;
  logic                     LOGIC_Flag;
  logic [OPERAND_WIDTH-1:0] CMP_OUT;
  logic                     CMP_Flag;
  logic [OPERAND_WIDTH-1:0] SHIFT_OUT;
  logic                     SHIFT_Flag;
  logic                     TX_READY;
  logic [7:0]               TX_DATA;
  logic                     TX_VALID;
  logic                     BUSY;
  logic                     DONE;
  logic                     OVERRUN;

  modport master (
    output ARITH_OUT, ARITH_Flag, LOGIC_OUT, LOGIC_Flag,
           CMP_OUT, CMP_Flag, SHIFT_OUT, SHIFT_Flag, TX_READY,
    input  TX_DATA, TX_VALID, BUSY, DONE, OVERRUN
  );

  modport slave (
    input  ARITH_OUT, ARITH_Flag, LOGIC_OUT, LOGIC_Flag,
           CMP_OUT, CMP_Flag, SHIFT_OUT, SHIFT_Flag, TX_READY,
    output TX_DATA, TX_VALID, BUSY, DONE, OVERRUN
  );
endinterface

// File: rtl/alu_result_serializer.sv
// Captures the highest-priority ALU result on a rising edge of any valid flag and streams it LSB byte first.
// Define RES_TAG_EN to prefix each result with a source tag byte (0xA1..0xA4).
module alu_result_serializer #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  alu_result_serializer_if.slave bus
);

  localparam int NB_ARITH = RESULT_WIDTH / 8;
  localparam int NB_OPND  = OPERAND_WIDTH / 8;
  localparam int CW       = $clog2(NB_ARITH + 1);

  // left_q counts bytes still to come after the one currently on TX_DATA
`ifdef RES_TAG_EN
  localparam logic [CW-1:0] ARITH_LEFT = CW'(NB_ARITH);
  localparam logic [CW-1:0] OPND_LEFT  = CW'(NB_OPND);
`else
  localparam logic [CW-1:0] ARITH_LEFT = CW'(NB_ARITH - 1);
  localparam logic [CW-1:0] OPND_LEFT  = CW'(NB_OPND - 1);
`endif

  localparam logic [1:0] IDLE = 2'd0;
`ifdef RES_TAG_EN
  localparam logic [1:0] TAG  = 2'd1;
`endif
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]              state;
  logic                    any_q;
  logic [RESULT_WIDTH-1:0] data_q;
  logic [CW-1:0]           left_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovr_q;

  logic                    any_flag;
  logic                    new_res;
  logic                    xfer;
  logic [RESULT_WIDTH-1:0] win_dat;
  logic [CW-1:0]           win_left;
`ifdef RES_TAG_EN
  logic [7:0]              win_tag;
`endif

  assign any_flag = bus.ARITH_Flag | bus.LOGIC_Flag | bus.CMP_Flag | bus.SHIFT_Flag;
  assign new_res  = any_flag & ~any_q;
  assign xfer     = tx_valid_q & bus.TX_READY;

  always_comb begin
    win_dat  = '0;
    win_left = OPND_LEFT;
`ifdef RES_TAG_EN
    win_tag  = 8'hA4;
`endif
    if (bus.ARITH_Flag) begin
      win_dat  = bus.ARITH_OUT;
      win_left = ARITH_LEFT;
`ifdef RES_TAG_EN
      win_tag  = 8'hA1;
`endif
    end else if (bus.LOGIC_Flag) begin
      win_dat[OPERAND_WIDTH-1:0] = bus.LOGIC_OUT;
`ifdef RES_TAG_EN
      win_tag  = 8'hA2;
`endif
    end else if (bus.CMP_Flag) begin
      win_dat[OPERAND_WIDTH-1:0] = bus.CMP_OUT;
`ifdef RES_TAG_EN
      win_tag  = 8'hA3;
`endif
    end else begin
      win_dat[OPERAND_WIDTH-1:0] = bus.SHIFT_OUT;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      any_q      <= 1'b0;
      data_q     <= '0;
      left_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      // edge history runs in every state so a level held across DONE never retriggers
      any_q  <= any_flag;
      done_q <= 1'b0;
      ovr_q  <= new_res && (state != IDLE);
      case (state)
        IDLE: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          tx_data_q  <= 8'h00;
          if (new_res) begin
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            left_q     <= win_left;
`ifdef RES_TAG_EN
            state      <= TAG;
            tx_data_q  <= win_tag;
            data_q     <= win_dat;
`else
            state      <= SEND;
            tx_data_q  <= win_dat[7:0];
            data_q     <= win_dat >> 8;
`endif
          end
        end
`ifdef RES_TAG_EN
        TAG: begin
          if (xfer) begin
            state     <= SEND;
            tx_data_q <= data_q[7:0];
            data_q    <= data_q >> 8;
            left_q    <= left_q - CW'(1);
          end
        end
`endif
        SEND: begin
          if (xfer) begin
            if (left_q == '0) begin
              state      <= IDLE;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              tx_data_q  <= 8'h00;
            end else begin
              tx_data_q <= data_q[7:0];
              data_q    <= data_q >> 8;
              left_q    <= left_q - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.OVERRUN  = ovr_q;

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream of the ALU execution units (arithmetic, logic, compare, shift).
- Captures whichever unit result becomes valid and splits it into bytes, LSB first.
- Streams the bytes over a valid/ready byte interface toward the UART TX path.
- Reports busy, done and overrun status back to the system controller.

Parameters:
OPERAND_WIDTH, 8, width of logic/compare/shift results; must be a multiple of 8
RESULT_WIDTH, 16, width of arithmetic result (holds multiply); multiple of 8, >= OPERAND_WIDTH

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
ARITH_OUT  in  RESULT_WIDTH  arithmetic unit result
ARITH_Flag  in  1  arithmetic result valid (level)
LOGIC_OUT  in  OPERAND_WIDTH  logic unit result
LOGIC_Flag  in  1  logic result valid (level)
CMP_OUT  in  OPERAND_WIDTH  compare unit result
CMP_Flag  in  1  compare result valid (level)
SHIFT_OUT  in  OPERAND_WIDTH  shift unit result
SHIFT_Flag  in  1  shift result valid (level)
TX_READY  in  1  downstream accepts byte this cycle
TX_DATA  out  8  byte to downstream
TX_VALID  out  1  TX_DATA valid
BUSY  out  1  serializer holds an unsent result
DONE  out  1  one-cycle pulse: last byte of a result accepted
OVERRUN  out  1  one-cycle pulse: new result dropped while BUSY

Behaviour:
- Reset (RST low, asynchronous): TX_DATA=0, TX_VALID=0, BUSY=0, DONE=0, OVERRUN=0; FSM to IDLE; flag-edge history cleared to 0.
- Flags are levels that stay high while the unit is enabled. The block registers ANY_FLAG = OR of the four flags. A new result is a rising edge of ANY_FLAG (current 1, previous 0).
- Source priority when several flags are high on the edge cycle: ARITH > LOGIC > CMP > SHIFT. Only the winner is captured.
- Capture (IDLE + edge in cycle N), all registered at N:
  - Data register gets the winner's result, zero-extended to RESULT_WIDTH.
  - Byte count = RESULT_WIDTH/8 for ARITH, OPERAND_WIDTH/8 otherwise.
  - BUSY=1, TX_VALID=1, TX_DATA=byte0, all visible from cycle N+1.
- States:
  - IDLE: waits for an edge.
  - TAG: present only with the optional feature.
  - SEND: TX_VALID=1, TX_DATA=current byte.
- Handshake in SEND:
  - Transfer occurs when TX_VALID && TX_READY.
  - TX_DATA stays stable while TX_READY=0.
  - After a transfer the next byte appears the following cycle with TX_VALID still 1, so back-to-back transfers are allowed at one byte per cycle.
- Last-byte transfer:
  - Next cycle: TX_VALID=0, BUSY=0, DONE=1 for one cycle, FSM to IDLE.
  - An edge arriving in that same cycle is captured normally.
- Edge while BUSY: result discarded, OVERRUN=1 for one cycle, current transfer unaffected.
- Edge detection continues in all states, so a flag held high across the end of a transfer does not retrigger.
- Reset mid-transfer: the in-flight result is lost and all outputs return to reset values immediately.

Optional Feature:
- Macro: RES_TAG_EN.
- Defined:
  - On capture the FSM enters TAG before SEND.
  - TAG presents one tag byte with TX_VALID=1 under the same handshake rules.
  - Tag values: 0xA1 ARITH, 0xA2 LOGIC, 0xA3 CMP, 0xA4 SHIFT.
  - Payload follows; DONE timing is unchanged relative to the last payload byte.
- Undefined: no TAG state; only payload bytes are sent.

Test Plan:
- Reset, then SHIFT_Flag high with SHIFT_OUT=0x5A, TX_READY=1 -> TX_VALID one cycle later with TX_DATA=0x5A (tag 0xA4 first if RES_TAG_EN); DONE pulses after the transfer; BUSY=0.
- ARITH_Flag with ARITH_OUT=0x1234, TX_READY=1 -> bytes 0x34 then 0x12 on consecutive cycles; DONE once.
- ARITH_OUT=0xBEEF with TX_READY held 0 for 3 cycles -> TX_DATA stays 0xEF, TX_VALID=1; then 0xEF, 0xBE transfer once TX_READY=1.
- LOGIC_Flag and CMP_Flag rise together (LOGIC_OUT=0x0F, CMP_OUT=0x02) -> only 0x0F sent (tag 0xA2 if enabled).
- While sending 0x1234 with TX_READY=0, SHIFT_Flag edge -> OVERRUN pulse; only 0x34, 0x12 emitted.
- Assert RST low mid-transfer -> TX_VALID, BUSY, DONE immediately 0; the next edge after reset starts a fresh transfer from byte0.
